// File: rtl/f1_start_sequencer.sv
// f1_start_sequencer: F1 start-light gantry sequencer (lamps, random hold, go pulse).
// Define JUMP_START_DET_EN to add jump-start detection (FAULT state, false_start flag).
module f1_start_sequencer #(
  parameter int NLIGHTS    = 10,
  parameter int STEP_TICKS = 500,
  parameter int LFSR_W     = 14,
  parameter int DELAY_MIN  = 200
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              tick,
  input  logic              trigger,
  input  logic [LFSR_W-1:0] lfsr_val,
  output logic              en_lfsr,
  output logic [9:0]        ledr,
  output logic              busy,
  output logic              go,
  output logic              false_start
);
  localparam int SW = $clog2(STEP_TICKS + 1);
  localparam int LW = $clog2(NLIGHTS + 1);
  localparam int DW = LFSR_W + 1;
  localparam logic [9:0] LMASK = 10'((1 << NLIGHTS) - 1);
`ifdef JUMP_START_DET_EN
  typedef enum logic [1:0] {IDLE, LIGHTS, DELAY, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, LIGHTS, DELAY} state_t;
`endif
  state_t state_q, state_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic [LW-1:0] lamp_idx_q, lamp_idx_d;
  logic [DW-1:0] dly_cnt_q, dly_cnt_d, delay_reg_q, delay_reg_d;
  logic [9:0] ledr_q, ledr_d;
  logic go_q, go_d, trigger_q, trg_rise, step_end;
  always_comb begin
    trg_rise = trigger & ~trigger_q;
    step_end = tick && step_cnt_q == SW'(STEP_TICKS - 1);
    state_d = state_q;
    step_cnt_d = step_cnt_q;
    lamp_idx_d = lamp_idx_q;
    dly_cnt_d = dly_cnt_q;
    delay_reg_d = delay_reg_q;
    ledr_d = ledr_q;
    go_d = 1'b0;
    case (state_q)
      IDLE: begin
        ledr_d = '0;
        if (trg_rise) begin
          delay_reg_d = DW'(DELAY_MIN) + DW'(lfsr_val);
          step_cnt_d = '0;
          lamp_idx_d = '0;
          state_d = LIGHTS;
        end
      end
      LIGHTS: if (step_end) begin
        ledr_d = ledr_q | (10'(1) << lamp_idx_q);
        lamp_idx_d = lamp_idx_q + LW'(1);
        step_cnt_d = '0;
        if (lamp_idx_q == LW'(NLIGHTS - 1)) begin
          dly_cnt_d = '0;
          state_d = DELAY;
        end
      end else if (tick) step_cnt_d = step_cnt_q + SW'(1);
      DELAY: if (tick && dly_cnt_q == delay_reg_q - DW'(1)) begin
        ledr_d = '0;
        go_d = 1'b1;
        state_d = IDLE;
      end else if (tick) dly_cnt_d = dly_cnt_q + DW'(1);
`ifdef JUMP_START_DET_EN
      FAULT: if (trg_rise) begin
        ledr_d = '0;
        state_d = IDLE;
      end else if (step_end) begin
        ledr_d = (ledr_q != '0) ? '0 : LMASK;
        step_cnt_d = '0;
      end else if (tick) step_cnt_d = step_cnt_q + SW'(1);
`endif
      default: state_d = IDLE;
    endcase
`ifdef JUMP_START_DET_EN
    // A jump start overrides any lamp/delay progress on the same edge
    if ((state_q == LIGHTS || state_q == DELAY) && trg_rise) begin
      state_d = FAULT;
      ledr_d = LMASK;
      step_cnt_d = '0;
      go_d = 1'b0;
    end
`endif
  end
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q <= IDLE;
      step_cnt_q <= '0;
      lamp_idx_q <= '0;
      dly_cnt_q <= '0;
      delay_reg_q <= '0;
      ledr_q <= '0;
      go_q <= 1'b0;
      trigger_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_cnt_q <= step_cnt_d;
      lamp_idx_q <= lamp_idx_d;
      dly_cnt_q <= dly_cnt_d;
      delay_reg_q <= delay_reg_d;
      ledr_q <= ledr_d;
      go_q <= go_d;
      trigger_q <= trigger;
    end
  end
  assign en_lfsr = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign ledr = ledr_q;
  assign go = go_q;
`ifdef JUMP_START_DET_EN
  assign false_start = state_q == FAULT;
`else
  assign false_start = 1'b0;
`endif
endmodule

// File: tb/tb_f1_start_sequencer.sv
// tb_f1_start_sequencer: random stimulus against a tick-count timeline model of the start sequence.
module tb_f1_start_sequencer;
  localparam int NL = 10, ST = 2, DMIN = 3;
  logic sysclk = 1'b0, rst, tick, trigger;
  logic [13:0] lfsr_val;
  logic en_lfsr, busy, go, false_start;
  logic [9:0] ledr;
  int n_vec = 0, n_err = 0;
  int active = 0, fault = 0, n = 0, fn = 0, dly = 0, go_e = 0, trig_prev = 0;
  f1_start_sequencer #(.NLIGHTS(NL), .STEP_TICKS(ST), .LFSR_W(14), .DELAY_MIN(DMIN)) dut (
    .sysclk(sysclk), .rst(rst), .tick(tick), .trigger(trigger), .lfsr_val(lfsr_val),
    .en_lfsr(en_lfsr), .ledr(ledr), .busy(busy), .go(go), .false_start(false_start)
  );
  always #5 sysclk = ~sysclk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int lamps(input int k);
    return (1 << k) - 1;
  endfunction
  task automatic cyc(input logic r, input logic t, input logic tr, input logic [13:0] lv);
    int rise, ledr_e;
    @(negedge sysclk);
    rst = r; tick = t; trigger = tr; lfsr_val = lv;
    @(posedge sysclk);
    rise = (tr && !trig_prev) ? 1 : 0;
    trig_prev = tr;
    go_e = 0;
    if (r) begin
      active = 0; fault = 0; trig_prev = 0;
    end else if (fault != 0) begin
      if (rise != 0) fault = 0;
      else if (t) fn++;
    end else if (active != 0) begin
`ifdef JUMP_START_DET_EN
      if (rise != 0) begin
        active = 0; fault = 1; fn = 0;
      end else begin
`else
      begin
`endif
        if (t) n++;
        if (n == NL * ST + dly) begin
          active = 0; go_e = 1;
        end
      end
    end else if (rise != 0) begin
      active = 1; n = 0; dly = DMIN + int'(lv);
    end
    ledr_e = (fault != 0) ? (((fn / ST) % 2 == 0) ? lamps(NL) : 0) :
             (active == 0) ? 0 : (n >= NL * ST) ? lamps(NL) : lamps(n / ST);
    #1;
    check("ledr", 32'(ledr), 32'(ledr_e));
    check("busy", 32'(busy), 32'(active != 0 || fault != 0));
    check("en_lfsr", 32'(en_lfsr), 32'(active == 0 && fault == 0));
    check("go", 32'(go), 32'(go_e));
    check("false_start", 32'(false_start), 32'(fault != 0));
  endtask
  initial begin
    int mode;
    rst = 1'b1; tick = 1'b0; trigger = 1'b0; lfsr_val = '0;
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 14'd0);
    cyc(1'b0, 1'b1, 1'b1, 14'd5);
    repeat (40) cyc(1'b0, 1'b1, 1'b0, 14'($urandom_range(0, 16383)));
    cyc(1'b0, 1'b0, 1'b1, 14'd0);
    for (int i = 0; i < 130; i++) cyc(1'b0, i % 4 == 3, 1'b0, 14'($urandom_range(0, 63)));
    cyc(1'b0, 1'b1, 1'b1, 14'd20);
    repeat (25) cyc(1'b0, 1'b1, 1'b0, 14'd0);
    cyc(1'b1, 1'b1, 1'b0, 14'd0);
    repeat (40) cyc(1'b0, 1'b1, 1'b0, 14'd0);
    for (int s = 0; s < 60; s++) begin
      mode = $urandom_range(0, 2);
      for (int i = 0; i < 150; i++)
        cyc($urandom_range(0, 299) == 0,
            mode == 0 ? 1'b1 : mode == 1 ? (i % 4 == 0) : 1'($urandom_range(0, 1)),
            $urandom_range(0, 15) == 0, 14'($urandom_range(0, 31)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
